// File: rtl/iq_sampler.sv
// Capture window and demod phase generator: gates sample_length cycles of 5-lane
// I/Q ADC data after start and tags each lane with an NCO phase in 1/15000 turns.
module iq_sampler (
    input  logic        clk100,
    input  logic        reset,
    input  logic        start,
    input  logic [79:0] data_i_in,
    input  logic [79:0] data_q_in,
    input  logic [3:0]  demod_freq,
    input  logic [10:0] sample_length,
    input  logic [5:0]  sample_freq,
    output logic [79:0] data_i_shift,
    output logic [79:0] data_q_shift,
    output logic [69:0] phase_vals,
    output logic        data_valid
);

    localparam int          LANES = 5;
    localparam int          DW    = 16;
    localparam int          PW    = 14;
    localparam logic [14:0] TURN  = 15'd15000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    r_state;
    logic [10:0]   r_cnt;
    logic [PW-1:0] r_base;
    logic [PW-1:0] r_inc;
    logic [2:0]    r_nlanes;
    logic [PW-1:0] r_off [LANES];

    logic [2:0]    w_lanes;
    logic [10:0]   w_unit;
    logic [14:0]   w_step;
    logic [14:0]   w_full;
    logic [PW-1:0] w_off [LANES];
    logic [79:0]   w_di;
    logic [79:0]   w_dq;
    logic [69:0]   w_ph;

    // Every caller guarantees v < 2*TURN, so a single conditional subtract suffices.
    function automatic logic [PW-1:0] mod_turn(input logic [14:0] v);
        return PW'((v >= TURN) ? (v - TURN) : v);
    endfunction

    assign w_lanes = (sample_freq == 6'd0 || sample_freq > 6'd5) ? 3'd5 : sample_freq[2:0];

    // 1500/S per unit of demod_freq; exact for every legal lane count.
    always_comb begin
        case (w_lanes)
            3'd1:    w_unit = 11'd1500;
            3'd2:    w_unit = 11'd750;
            3'd3:    w_unit = 11'd500;
            3'd4:    w_unit = 11'd375;
            default: w_unit = 11'd300;
        endcase
    end

    assign w_step = 15'(demod_freq) * {4'b0, w_unit};
    assign w_full = 15'(demod_freq) * 15'd1500;

    // Active lanes satisfy k*STEP < 1500*demod_freq <= 22500, so one subtract wraps them.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_off[k] = (3'(k) < w_lanes) ? mod_turn(15'(k) * w_step) : '0;
        end
    end

    always_comb begin
        w_di = '0;
        w_dq = '0;
        w_ph = '0;
        for (int k = 0; k < LANES; k++) begin
            if (3'(k) < r_nlanes) begin
                w_di[k*DW +: DW] = data_i_in[k*DW +: DW];
                w_dq[k*DW +: DW] = data_q_in[k*DW +: DW];
                w_ph[k*PW +: PW] = mod_turn({1'b0, r_base} + {1'b0, r_off[k]});
            end
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_inc        <= '0;
            r_nlanes     <= 3'd5;
            for (int k = 0; k < LANES; k++) r_off[k] <= '0;
            data_i_shift <= '0;
            data_q_shift <= '0;
            phase_vals   <= '0;
            data_valid   <= 1'b0;
        end else begin
            data_i_shift <= '0;
            data_q_shift <= '0;
            phase_vals   <= '0;
            data_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_nlanes <= w_lanes;
                        r_inc    <= mod_turn(w_full);
                        for (int k = 0; k < LANES; k++) r_off[k] <= w_off[k];
                        r_base   <= '0;
                        r_cnt    <= sample_length;
                        r_state  <= (sample_length == 11'd0) ? ST_HOLD : ST_RUN;
                    end
                end
                ST_RUN: begin
                    data_i_shift <= w_di;
                    data_q_shift <= w_dq;
                    phase_vals   <= w_ph;
                    data_valid   <= 1'b1;
                    r_base       <= mod_turn({1'b0, r_base} + {1'b0, r_inc});
                    r_cnt        <= r_cnt - 11'd1;
                    if (r_cnt == 11'd1) r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!start) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_sampler.sv
// Directed bench for iq_sampler: window length, phase sequence, lane masking,
// start re-arm, reset abort and config latching.
module tb_iq_sampler;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        start;
    logic [79:0] data_i_in;
    logic [79:0] data_q_in;
    logic [3:0]  demod_freq;
    logic [10:0] sample_length;
    logic [5:0]  sample_freq;
    logic [79:0] data_i_shift;
    logic [79:0] data_q_shift;
    logic [69:0] phase_vals;
    logic        data_valid;

    int total = 0;
    int bad   = 0;
    int tick  = 0;

    iq_sampler dut (
        .clk100        (clk100),
        .reset         (reset),
        .start         (start),
        .data_i_in     (data_i_in),
        .data_q_in     (data_q_in),
        .demod_freq    (demod_freq),
        .sample_length (sample_length),
        .sample_freq   (sample_freq),
        .data_i_shift  (data_i_shift),
        .data_q_shift  (data_q_shift),
        .phase_vals    (phase_vals),
        .data_valid    (data_valid)
    );

    always #5 clk100 = ~clk100;

    function automatic logic [15:0] pat(input int t, input int k);
        logic [31:0] tv;
        tv = t;
        return {tv[11:0], 4'(k)};
    endfunction

    // New ADC word every cycle; the word captured at an edge is pat(tick-1) at the next negedge.
    always @(posedge clk100) begin
        #2;
        tick = tick + 1;
        for (int k = 0; k < 5; k++) begin
            data_i_in[k*16 +: 16] = pat(tick, k);
            data_q_in[k*16 +: 16] = ~pat(tick, k);
        end
    end

    function automatic logic [79:0] exp_data(input int t, input int s, input bit q);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < s; k++) r[k*16 +: 16] = q ? ~pat(t, k) : pat(t, k);
        return r;
    endfunction

    function automatic logic [69:0] exp_phase(input int n, input int d, input int s);
        logic [69:0] r;
        longint v;
        r = '0;
        for (int k = 0; k < s; k++) begin
            v = (longint'(n) * 1500 * d + (k * 1500 * d) / s) % 15000;
            r[k*14 +: 14] = 14'(v);
        end
        return r;
    endfunction

    function automatic logic [69:0] pack5(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
        return {14'(a4), 14'(a3), 14'(a2), 14'(a1), 14'(a0)};
    endfunction

    task automatic start_cap(input int d, input int len, input int s);
        @(negedge clk100);
        demod_freq    = 4'(d);
        sample_length = 11'(len);
        sample_freq   = 6'(s);
        start         = 1'b1;
    endtask

    task automatic rearm_gap();
        @(negedge clk100);
        start = 1'b0;
        repeat (3) @(negedge clk100);
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk100);
            if (data_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Walks the rest of a window from valid-cycle index n0, counting cycles and deviations.
    task automatic collect(input int d, input int s, input int n0, input int maxc,
                           output int n, output int errs);
        n = n0;
        errs = 0;
        while (data_valid === 1'b1 && n < maxc) begin
            if (phase_vals !== exp_phase(n, d, s) ||
                data_i_shift !== exp_data(tick - 1, s, 1'b0) ||
                data_q_shift !== exp_data(tick - 1, s, 1'b1)) begin
                if (errs == 0)
                    $display("  deviation at valid cycle %0d: phase %h want %h",
                             n, phase_vals, exp_phase(n, d, s));
                errs++;
            end
            n++;
            @(negedge clk100);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        demod_freq = '0; sample_length = '0; sample_freq = '0;
        repeat (3) @(negedge clk100);
        total++;
        if (data_valid !== 1'b0 || phase_vals !== '0 || data_i_shift !== '0 || data_q_shift !== '0)
            $display("FAIL reset_outputs: valid=%b phase=%h di=%h dq=%h want all 0",
                     data_valid, phase_vals, data_i_shift, data_q_shift);
        if (data_valid !== 1'b0 || phase_vals !== '0 || data_i_shift !== '0 || data_q_shift !== '0)
            bad++;
        @(negedge clk100);
        reset = 1'b0;
        repeat (2) @(negedge clk100);
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_valid: valid=%b want 0", data_valid);
        end
    endtask

    task automatic test_basic_window();
        bit ok;
        int n, errs;
        logic [69:0] lit [3];
        lit[0] = pack5(0, 1500, 3000, 4500, 6000);
        lit[1] = pack5(7500, 9000, 10500, 12000, 13500);
        lit[2] = pack5(0, 1500, 3000, 4500, 6000);
        start_cap(5, 2000, 5);
        wait_valid(5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_first_valid: timeout want valid within 5"); end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (phase_vals !== lit[c] || data_i_shift !== exp_data(tick - 1, 5, 1'b0)) begin
                bad++;
                $display("FAIL basic_cycle%0d: phase=%h di=%h want phase=%h di=%h", c,
                         phase_vals, data_i_shift, lit[c], exp_data(tick - 1, 5, 1'b0));
            end
            @(negedge clk100);
        end
        collect(5, 5, 3, 2100, n, errs);
        total++;
        if (errs !== 0) begin bad++; $display("FAIL basic_stream: bad cycles=%0d want 0", errs); end
        total++;
        if (n !== 2000) begin bad++; $display("FAIL basic_length: valid cycles=%0d want 2000", n); end
    endtask

    task automatic test_hold_rearm();
        bit ok;
        int n, errs, seen;
        seen = 0;
        repeat (20) begin
            @(negedge clk100);
            if (data_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL hold_start_high: valid cycles=%0d want 0", seen); end
        rearm_gap();
        start_cap(5, 2000, 5);
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== pack5(0, 1500, 3000, 4500, 6000)) begin
            bad++;
            $display("FAIL rearm_phase0: ok=%b phase=%h want %h", ok, phase_vals,
                     pack5(0, 1500, 3000, 4500, 6000));
        end
        @(negedge clk100);
        collect(5, 5, 1, 2100, n, errs);
        total++;
        if (errs !== 0 || n !== 2000) begin
            bad++;
            $display("FAIL rearm_window: cycles=%0d bad=%0d want 2000/0", n, errs);
        end
    endtask

    task automatic test_two_lanes();
        bit ok;
        int n, errs;
        rearm_gap();
        start_cap(3, 4, 2);
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== pack5(0, 2250, 0, 0, 0) || data_i_shift[79:32] !== 48'd0 ||
            data_q_shift[79:32] !== 48'd0 || data_i_shift[31:0] !== exp_data(tick - 1, 2, 1'b0)) begin
            bad++;
            $display("FAIL s2_cycle0: phase=%h di=%h want phase=%h di=%h", phase_vals,
                     data_i_shift, pack5(0, 2250, 0, 0, 0), exp_data(tick - 1, 2, 1'b0));
        end
        @(negedge clk100);
        total++;
        if (phase_vals !== pack5(4500, 6750, 0, 0, 0)) begin
            bad++;
            $display("FAIL s2_cycle1: phase=%h want %h", phase_vals, pack5(4500, 6750, 0, 0, 0));
        end
        collect(3, 2, 1, 20, n, errs);
        total++;
        if (errs !== 0 || n !== 4) begin
            bad++;
            $display("FAIL s2_window: cycles=%0d bad=%0d want 4/0", n, errs);
        end
    endtask

    task automatic test_len_edges();
        bit ok;
        int seen;
        rearm_gap();
        start_cap(5, 0, 5);
        seen = 0;
        repeat (10) begin
            @(negedge clk100);
            if (data_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL len0_valid: valid cycles=%0d want 0", seen); end
        total++;
        if (dut.r_state !== 2'd2) begin bad++; $display("FAIL len0_state: state=%0d want 2", dut.r_state); end
        rearm_gap();
        start_cap(5, 1, 5);
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== pack5(0, 1500, 3000, 4500, 6000)) begin
            bad++;
            $display("FAIL len1_cycle0: ok=%b phase=%h want %h", ok, phase_vals,
                     pack5(0, 1500, 3000, 4500, 6000));
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk100);
            if (data_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL len1_extra: extra valid cycles=%0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, errs;
        rearm_gap();
        start_cap(5, 2000, 5);
        wait_valid(5, ok);
        repeat (100) @(negedge clk100);
        total++;
        if (data_valid !== 1'b1) begin bad++; $display("FAIL mid_running: valid=%b want 1", data_valid); end
        reset = 1'b1;
        #1;
        total++;
        if (data_valid !== 1'b0 || phase_vals !== '0 || data_i_shift !== '0 || data_q_shift !== '0) begin
            bad++;
            $display("FAIL mid_reset_clear: valid=%b phase=%h di=%h want all 0",
                     data_valid, phase_vals, data_i_shift);
        end
        @(negedge clk100);
        reset = 1'b0;
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== pack5(0, 1500, 3000, 4500, 6000)) begin
            bad++;
            $display("FAIL mid_restart_phase: ok=%b phase=%h want %h", ok, phase_vals,
                     pack5(0, 1500, 3000, 4500, 6000));
        end
        collect(5, 5, 0, 2100, n, errs);
        total++;
        if (errs !== 0 || n !== 2000) begin
            bad++;
            $display("FAIL mid_restart_window: cycles=%0d bad=%0d want 2000/0", n, errs);
        end
    endtask

    task automatic test_config_latch();
        bit ok;
        int n, errs;
        rearm_gap();
        start_cap(5, 50, 5);
        wait_valid(5, ok);
        demod_freq = 4'd7; sample_length = 11'd3; sample_freq = 6'd2; start = 1'b0;
        collect(5, 5, 0, 100, n, errs);
        total++;
        if (!ok || errs !== 0 || n !== 50) begin
            bad++;
            $display("FAIL cfg_ignored: cycles=%0d bad=%0d want 50/0", n, errs);
        end
        repeat (2) @(negedge clk100);
        start = 1'b1;
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== pack5(0, 5250, 0, 0, 0)) begin
            bad++;
            $display("FAIL cfg_new_c0: phase=%h want %h", phase_vals, pack5(0, 5250, 0, 0, 0));
        end
        @(negedge clk100);
        total++;
        if (phase_vals !== pack5(10500, 750, 0, 0, 0)) begin
            bad++;
            $display("FAIL cfg_new_c1: phase=%h want %h", phase_vals, pack5(10500, 750, 0, 0, 0));
        end
        @(negedge clk100);
        total++;
        if (phase_vals !== pack5(6000, 11250, 0, 0, 0)) begin
            bad++;
            $display("FAIL cfg_new_c2: phase=%h want %h", phase_vals, pack5(6000, 11250, 0, 0, 0));
        end
        @(negedge clk100);
        total++;
        if (data_valid !== 1'b0) begin bad++; $display("FAIL cfg_new_len: valid=%b want 0", data_valid); end
    endtask

    task automatic test_demod_extremes();
        bit ok;
        int n, errs;
        rearm_gap();
        start_cap(0, 3, 3);
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== '0 || data_i_shift !== exp_data(tick - 1, 3, 1'b0)) begin
            bad++;
            $display("FAIL demod0: phase=%h di=%h want 0 / %h", phase_vals, data_i_shift,
                     exp_data(tick - 1, 3, 1'b0));
        end
        collect(0, 3, 0, 10, n, errs);
        total++;
        if (errs !== 0 || n !== 3) begin bad++; $display("FAIL demod0_window: cycles=%0d bad=%0d want 3/0", n, errs); end
        rearm_gap();
        start_cap(15, 3, 1);
        wait_valid(5, ok);
        total++;
        if (!ok || phase_vals !== '0 || data_i_shift[79:16] !== 64'd0) begin
            bad++;
            $display("FAIL demod15_c0: phase=%h di=%h want phase 0, lanes 1-4 zero", phase_vals, data_i_shift);
        end
        @(negedge clk100);
        total++;
        if (phase_vals !== pack5(7500, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL demod15_c1: phase=%h want %h", phase_vals, pack5(7500, 0, 0, 0, 0));
        end
        @(negedge clk100);
        total++;
        if (phase_vals !== '0 || data_valid !== 1'b1) begin
            bad++;
            $display("FAIL demod15_c2: phase=%h valid=%b want 0/1", phase_vals, data_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_hold_rearm();
        test_two_lanes();
        test_len_edges();
        test_reset_mid();
        test_config_latch();
        test_demod_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
